// File: rtl/chicken_turn_engine.sv
// Turn engine for the Chicken Cha-Cha-Cha board: tile picture RAM, chicken
// positions and tails, landing-tile scan, picture compare, tail stealing and win.
module chicken_turn_engine #(
  parameter  int MAX_PLAYERS = 4,
  parameter  int TRACK_LEN   = 16,
  parameter  int PIC_W       = 4,
  parameter  int STRIDE      = 4,
  localparam int POS_W       = $clog2(TRACK_LEN),
  localparam int PL_W        = $clog2(MAX_PLAYERS),
  localparam int TL_W        = $clog2(MAX_PLAYERS + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PL_W:0]                num_players,
  input  logic                         start,
  input  logic                         tile_we,
  input  logic [POS_W-1:0]             tile_addr,
  input  logic [PIC_W-1:0]             tile_pic,
  input  logic                         guess_valid,
  input  logic [PIC_W-1:0]             guess_pic,
  output logic                         ready,
  output logic [PL_W-1:0]              cur_player,
  output logic                         result_valid,
  output logic                         result_match,
  output logic                         win,
  output logic [PL_W-1:0]              winner,
  output logic [MAX_PLAYERS*POS_W-1:0] pos_bus,
  output logic [MAX_PLAYERS*TL_W-1:0]  tails_bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_READY, S_SCAN, S_COMPARE, S_UPDATE, S_WIN
  } state_t;

  state_t                 r_state;
  logic [PIC_W-1:0]       r_tiles [TRACK_LEN];
  logic [POS_W-1:0]       r_pos   [MAX_PLAYERS];
  logic [TL_W-1:0]        r_tails [MAX_PLAYERS];
  logic [MAX_PLAYERS-1:0] r_active;
  logic [MAX_PLAYERS-1:0] r_skip;
  logic [PL_W:0]          r_np;
  logic [PL_W-1:0]        r_cur;
  logic [PIC_W-1:0]       r_guess;
  logic [POS_W-1:0]       r_scan;
  logic [POS_W-1:0]       r_target;
  logic                   r_ready;
  logic                   r_result_valid;
  logic                   r_result_match;
  logic                   r_win;
  logic [PL_W-1:0]        r_winner;

  logic [MAX_PLAYERS-1:0] w_hit;
  logic [TL_W-1:0]        w_steal;
  logic [TL_W-1:0]        w_new_tails;
  logic                   w_win_now;
  logic [PL_W:0]          w_np;
  logic [PL_W:0]          w_cur_inc;
  logic [PL_W-1:0]        w_cur_next;
  logic                   w_tile_open;

  function automatic logic [PL_W:0] clamp_np(input logic [PL_W:0] n);
    if (n < (PL_W+1)'(2))                return (PL_W+1)'(2);
    if (n > (PL_W+1)'(MAX_PLAYERS))      return (PL_W+1)'(MAX_PLAYERS);
    return n;
  endfunction

  function automatic logic [POS_W-1:0] next_pos(input logic [POS_W-1:0] p);
    if (int'(p) == TRACK_LEN - 1) return '0;
    return p + POS_W'(1);
  endfunction

  assign w_np        = clamp_np(num_players);
  assign w_cur_inc   = {1'b0, r_cur} + (PL_W+1)'(1);
  assign w_cur_next  = (w_cur_inc == r_np) ? '0 : w_cur_inc[PL_W-1:0];
  assign w_tile_open = (r_state == S_IDLE) || (r_state == S_WIN);

  // Which active chicken, if any, sits on the tile currently being scanned
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < MAX_PLAYERS; i++)
      w_hit[i] = r_active[i] && (r_pos[i] == r_scan);
  end

  always_comb begin
    w_steal = '0;
    for (int i = 0; i < MAX_PLAYERS; i++)
      if (r_skip[i]) w_steal = w_steal + r_tails[i];
    w_new_tails = r_tails[r_cur] + w_steal;
    w_win_now   = (int'(w_new_tails) == int'(r_np));
  end

  always_comb begin
    pos_bus   = '0;
    tails_bus = '0;
    for (int i = 0; i < MAX_PLAYERS; i++) begin
      pos_bus[i*POS_W +: POS_W] = r_pos[i];
      tails_bus[i*TL_W +: TL_W] = r_tails[i];
    end
  end

  assign ready        = r_ready;
  assign cur_player   = r_cur;
  assign result_valid = r_result_valid;
  assign result_match = r_result_match;
  assign win          = r_win;
  assign winner       = r_winner;

  // Picture RAM keeps its contents through reset; only writable between games
  always_ff @(posedge clk) begin
    if (tile_we && w_tile_open && (int'(tile_addr) < TRACK_LEN))
      r_tiles[tile_addr] <= tile_pic;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_active       <= '0;
      r_skip         <= '0;
      r_np           <= '0;
      r_cur          <= '0;
      r_guess        <= '0;
      r_scan         <= '0;
      r_target       <= '0;
      r_ready        <= 1'b0;
      r_result_valid <= 1'b0;
      r_result_match <= 1'b0;
      r_win          <= 1'b0;
      r_winner       <= '0;
      for (int i = 0; i < MAX_PLAYERS; i++) begin
        r_pos[i]   <= '0;
        r_tails[i] <= '0;
      end
    end else begin
      r_result_valid <= 1'b0;
      case (r_state)
        S_IDLE, S_WIN: begin
          if (start) begin
            r_np     <= w_np;
            r_cur    <= '0;
            r_win    <= 1'b0;
            r_winner <= '0;
            r_ready  <= 1'b1;
            r_state  <= S_READY;
            for (int i = 0; i < MAX_PLAYERS; i++) begin
              if ((PL_W+1)'(i) < w_np) begin
                r_active[i] <= 1'b1;
                r_pos[i]    <= POS_W'(i * STRIDE);
                r_tails[i]  <= TL_W'(1);
              end else begin
                r_active[i] <= 1'b0;
                r_pos[i]    <= '0;
                r_tails[i]  <= '0;
              end
            end
          end
        end
        S_READY: begin
          if (guess_valid) begin
            r_guess <= guess_pic;
            r_scan  <= next_pos(r_pos[r_cur]);
            r_skip  <= '0;
            r_ready <= 1'b0;
            r_state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (|w_hit) begin
            r_skip <= r_skip | w_hit;
            r_scan <= next_pos(r_scan);
          end else begin
            r_target <= r_scan;
            r_state  <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          r_result_match <= (r_tiles[r_target] == r_guess);
          r_result_valid <= 1'b1;
          r_state        <= S_UPDATE;
        end
        S_UPDATE: begin
          if (r_result_match) begin
            r_pos[r_cur] <= r_target;
            for (int i = 0; i < MAX_PLAYERS; i++)
              if (r_skip[i]) r_tails[i] <= '0;
            r_tails[r_cur] <= w_new_tails;
            if (w_win_now) begin
              r_win    <= 1'b1;
              r_winner <= r_cur;
              r_state  <= S_WIN;
            end else begin
              r_ready <= 1'b1;
              r_state <= S_READY;
            end
          end else begin
            r_cur   <= w_cur_next;
            r_ready <= 1'b1;
            r_state <= S_READY;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chicken_turn_engine.sv
// Scoreboard bench for chicken_turn_engine: directed game scenarios followed by
// randomized games, checked against a plain-arithmetic model of the board rules.
module tb_chicken_turn_engine;
  localparam int MP = 4, TL = 16, PW = 4, ST = 4;
  localparam int POS_W = 4, PL_W = 2, TL_W = 3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [PL_W:0]         num_players;
  logic                  start, tile_we, guess_valid;
  logic [POS_W-1:0]      tile_addr;
  logic [PW-1:0]         tile_pic, guess_pic;
  logic                  ready, result_valid, result_match, win;
  logic [PL_W-1:0]       cur_player, winner;
  logic [MP*POS_W-1:0]   pos_bus;
  logic [MP*TL_W-1:0]    tails_bus;

  always #5 clk = ~clk;

  chicken_turn_engine #(.MAX_PLAYERS(MP), .TRACK_LEN(TL), .PIC_W(PW), .STRIDE(ST)) dut (
    .clk(clk), .rst(rst), .num_players(num_players), .start(start),
    .tile_we(tile_we), .tile_addr(tile_addr), .tile_pic(tile_pic),
    .guess_valid(guess_valid), .guess_pic(guess_pic), .ready(ready),
    .cur_player(cur_player), .result_valid(result_valid), .result_match(result_match),
    .win(win), .winner(winner), .pos_bus(pos_bus), .tails_bus(tails_bus));

  int total = 0, bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit                match;
    int                acc, lat, cur, winner;
    bit                win;
    logic [MP*POS_W-1:0] pos;
    logic [MP*TL_W-1:0]  tails;
  } exp_t;
  exp_t q[$];

  int m_pos[MP], m_tails[MP], m_tiles[TL];
  int m_np, m_cur, m_winner;
  bit m_win;

  task automatic chk(input string nm, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic int owner(input int t);
    for (int j = 0; j < m_np; j++) if (m_pos[j] == t) return j;
    return -1;
  endfunction

  function automatic int landing();
    int t = (m_pos[m_cur] + 1) % TL;
    while (owner(t) >= 0) t = (t + 1) % TL;
    return t;
  endfunction

  function automatic logic [MP*POS_W-1:0] pos_vec();
    logic [MP*POS_W-1:0] v = '0;
    for (int j = 0; j < MP; j++) v[j*POS_W +: POS_W] = POS_W'(m_pos[j]);
    return v;
  endfunction

  function automatic logic [MP*TL_W-1:0] tails_vec();
    logic [MP*TL_W-1:0] v = '0;
    for (int j = 0; j < MP; j++) v[j*TL_W +: TL_W] = TL_W'(m_tails[j]);
    return v;
  endfunction

  // Apply one guess to the model and queue the response it implies
  task automatic model_guess(input int pic, input int acc);
    exp_t e;
    int t, k, o;
    bit sk[MP];
    for (int j = 0; j < MP; j++) sk[j] = 0;
    t = (m_pos[m_cur] + 1) % TL;
    k = 0;
    o = owner(t);
    while (o >= 0) begin
      sk[o] = 1; k++; t = (t + 1) % TL; o = owner(t);
    end
    e.match = (m_tiles[t] == pic);
    e.lat = 3 + k;
    e.acc = acc;
    if (e.match) begin
      m_pos[m_cur] = t;
      for (int j = 0; j < MP; j++)
        if (sk[j]) begin m_tails[m_cur] += m_tails[j]; m_tails[j] = 0; end
      if (m_tails[m_cur] == m_np) begin m_win = 1; m_winner = m_cur; end
    end else begin
      m_cur = (m_cur + 1) % m_np;
    end
    e.pos = pos_vec(); e.tails = tails_vec(); e.cur = m_cur;
    e.win = m_win; e.winner = m_winner;
    q.push_back(e);
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_ready"}, ready, 0);
    chk({nm, "_cur"}, cur_player, 0);
    chk({nm, "_rvalid"}, result_valid, 0);
    chk({nm, "_rmatch"}, result_match, 0);
    chk({nm, "_win"}, win, 0);
    chk({nm, "_winner"}, winner, 0);
    chk({nm, "_pos"}, pos_bus, 0);
    chk({nm, "_tails"}, tails_bus, 0);
  endtask

  task automatic write_tile(input int a, input int p);
    tile_we = 1'b1; tile_addr = POS_W'(a); tile_pic = PW'(p);
    @(negedge clk);
    tile_we = 1'b0;
    m_tiles[a] = p;
  endtask

  task automatic do_start(input int n);
    num_players = (PL_W+1)'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_np = (n < 2) ? 2 : (n > MP) ? MP : n;
    for (int j = 0; j < MP; j++) begin
      m_pos[j]   = (j < m_np) ? j * ST : 0;
      m_tails[j] = (j < m_np) ? 1 : 0;
    end
    m_cur = 0; m_win = 0; m_winner = 0;
    chk("start_pos", pos_bus, pos_vec());
    chk("start_tails", tails_bus, tails_vec());
    chk("start_cur", cur_player, 0);
    chk("start_ready", ready, 1);
    chk("start_win", win, 0);
  endtask

  // guess_valid stays high through SCAN/COMPARE until the result shows
  task automatic guess(input int pic);
    int n = 0;
    while (!ready && n < 50) begin @(negedge clk); n++; end
    if (!ready) begin chk("ready_wait", ready, 1); return; end
    model_guess(pic, cyc);
    guess_valid = 1'b1; guess_pic = PW'(pic);
    n = 0;
    do begin @(negedge clk); n++; end while (!result_valid && n < 40);
    guess_valid = 1'b0;
    if (!result_valid) chk("result_wait", result_valid, 1);
    @(negedge clk);
  endtask

  task automatic reset_pulse(input string nm);
    rst = 1'b0;
    @(negedge clk);
    check_zero(nm);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (result_valid) begin
        if (q.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          e = q.pop_front();
          chk("result_match", result_match, e.match);
          chk("latency", cyc - e.acc, e.lat);
          @(negedge clk);
          chk("pos_bus", pos_bus, e.pos);
          chk("tails_bus", tails_bus, e.tails);
          chk("cur_player", cur_player, e.cur);
          chk("win", win, e.win);
          chk("ready_after", ready, !e.win);
          if (e.win) chk("winner", winner, e.winner);
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int dt[TL];
    int pic;
    dt = '{11, 5, 7, 3, 1, 9, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
    rst = 1'b0; start = 1'b0; tile_we = 1'b0; guess_valid = 1'b0;
    num_players = '0; tile_addr = '0; tile_pic = '0; guess_pic = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;
    @(negedge clk);
    for (int a = 0; a < TL; a++) write_tile(a, dt[a]);

    do_start(4);
    guess(6); guess(0); guess(0); guess(0);
    chk("turn_wraps_to_0", cur_player, 0);
    guess(5);
    chk("simple_match_pos0", pos_bus[0 +: POS_W], 1);
    guess(7); guess(3); guess(9);
    chk("hop_pos0", pos_bus[0 +: POS_W], 5);
    chk("hop_tails0", tails_bus[0 +: TL_W], 2);
    chk("hop_tails1", tails_bus[TL_W +: TL_W], 0);

    tile_we = 1'b1; tile_addr = 4'd6; tile_pic = 4'd15;
    @(negedge clk);
    tile_we = 1'b0;
    guess(6);
    chk("ram_unchanged_pos0", pos_bus[0 +: POS_W], 6);

    guess(0); guess(0); guess(0);
    chk("turn_at_3", cur_player, 3);
    guess(13); guess(14); guess(15); guess(11);
    chk("wrap_pos3", pos_bus[3*POS_W +: POS_W], 0);

    guess_valid = 1'b1; guess_pic = 4'd0;
    @(negedge clk);
    guess_valid = 1'b0;
    reset_pulse("mid_scan");

    do_start(2);
    guess(5); guess(7); guess(3); guess(9);
    chk("win_flag", win, 1);
    chk("win_winner", winner, 0);
    chk("win_tails0", tails_bus[0 +: TL_W], 2);
    for (int i = 0; i < 5; i++) begin
      guess_valid = 1'b1; guess_pic = 4'd5;
      @(negedge clk);
      chk("ready_after_win", ready, 0);
      chk("win_held", win, 1);
    end
    guess_valid = 1'b0;

    for (int g = 0; g < 4; g++) begin
      for (int a = 0; a < TL; a++) write_tile(a, $urandom_range(0, 15));
      do_start($urandom_range(0, 7));
      for (int n = 0; n < 60 && !m_win; n++) begin
        pic = ($urandom_range(0, 1) == 1) ? m_tiles[landing()] : $urandom_range(0, 15);
        guess(pic);
      end
      if (!m_win) reset_pulse("rand_reset");
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/chicken_turn_engine.md
Name: chicken_turn_engine

Overview:
Parametrised game datapath for the Chicken Cha-Cha-Cha board. It holds the egg-tile picture RAM, every chicken's track position, every chicken's tail count and whose turn it is. It resolves each card guess: it scans for the landing tile, compares the picture, moves the chicken, steals tails and rotates the turn. It also detects the win. It sits between the card/keypad front-end and the display/score logic, and generalises the earlier fixed 2-bit-player data path to MAX_PLAYERS chickens on a circular track of TRACK_LEN tiles.

Parameters:
MAX_PLAYERS, 4, maximum number of chickens; must be 2 or more.
TRACK_LEN, 16, number of tiles on the circular track; must be greater than MAX_PLAYERS.
PIC_W, 4, picture ID width.
STRIDE, 4, start spacing: chicken i starts on tile i*STRIDE; requires STRIDE*MAX_PLAYERS <= TRACK_LEN.
POS_W, clog2(TRACK_LEN), position width (derived).
PL_W, clog2(MAX_PLAYERS), player index width (derived).
TL_W, clog2(MAX_PLAYERS+1), tail count width (derived).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-low reset.
num_players  in  PL_W+1  active chicken count; sampled only on start.
start  in  1  one-cycle pulse; new game.
tile_we  in  1  tile RAM write strobe.
tile_addr  in  POS_W  tile RAM address.
tile_pic  in  PIC_W  picture written to the tile.
guess_valid  in  1  card guess offered.
guess_pic  in  PIC_W  picture on the flipped card.
ready  out  1  a guess can be accepted.
cur_player  out  PL_W  index of the chicken whose turn it is.
result_valid  out  1  one-cycle pulse; guess resolved.
result_match  out  1  qualified by result_valid; 1 = picture matched.
win  out  1  game over; held until start or reset.
winner  out  PL_W  index of the winning chicken; valid while win=1.
pos_bus  out  MAX_PLAYERS*POS_W  chicken positions; chicken i occupies slice i.
tails_bus  out  MAX_PLAYERS*TL_W  tail counts; chicken i occupies slice i.

Behaviour:
- Reset (rst=0 at a clock edge): state goes to IDLE. All outputs go to 0: ready, cur_player, result_valid, result_match, win, winner, pos_bus, tails_bus. Tile RAM contents are not cleared.
- States: IDLE, READY, SCAN, COMPARE, UPDATE, WIN.
- Tile writes:
  - Taken only in IDLE or WIN.
  - tile_we in any other state is ignored.
- start:
  - Honoured in IDLE or WIN; ignored in other states.
  - num_players is clamped: values below 2 act as 2, values above MAX_PLAYERS act as MAX_PLAYERS.
  - Active chicken i gets position i*STRIDE and 1 tail.
  - Inactive chickens report position 0 and 0 tails, and never occupy a tile.
  - cur_player=0, win=0. Next state is READY.
- READY:
  - ready=1 only in READY.
  - Handshake: a guess is accepted on the cycle where ready and guess_valid are both 1. guess_pic is latched. Next state is SCAN.
  - guess_valid in any other state is ignored; no queuing.
- SCAN:
  - One tile per cycle, starting at (pos[cur]+1) mod TRACK_LEN.
  - If the tile is occupied by an active chicken, that chicken is set in a skip mask and the scan advances.
  - The first free tile becomes the target. Next state is COMPARE.
  - Wrap: all position arithmetic is mod TRACK_LEN.
  - The scan always terminates because TRACK_LEN > MAX_PLAYERS.
- COMPARE: reads tile_pic at the target and compares it to the latched guess; takes 1 cycle.
- UPDATE (1 cycle):
  - result_valid=1 and result_match = compare result.
  - On match:
    - pos[cur] becomes the target.
    - tails[cur] += the sum of tails of all chickens in the skip mask, and those chickens' tails go to 0.
    - The turn is kept.
    - If the new tails[cur] equals the clamped num_players, next state is WIN with win=1 and winner=cur. Otherwise next state is READY.
  - On mismatch: no move, no steal; cur_player becomes (cur+1) mod clamped num_players; next state is READY.
- Latency: for a guess accepted at cycle t with k chickens skipped, result_valid is high at t+3+k. ready returns at t+4+k unless the game is won.
- Stolen counts never overflow TL_W because the total tail count is conserved and equals num_players.
- A chicken with 0 tails stays on the track, can still be hopped, and keeps taking turns.
- Reset mid-SCAN/COMPARE/UPDATE: the guess is abandoned and the next state is IDLE with no partial move or steal.

Test Plan:
- Init: num_players=4, start -> pos_bus slices = 0,4,8,12; tails = 1,1,1,1; cur_player=0; ready=1 on the next cycle.
- Simple match: tile1 loaded with pic 5; guess 5 -> result_valid exactly 3 cycles after accept with result_match=1; pos[0]=1; cur_player stays 0.
- Mismatch: tile1=5, guess 6 -> result_match=0; pos[0]=0; cur_player goes 0->1; a later mismatch by player 3 returns the turn to 0.
- Hop and steal: num_players=4; chicken 0 at 3 after matches, tile5=9; guess 9 -> skips chicken 1 at tile 4, result_valid at t+4; pos[0]=5; tails[0]=2, tails[1]=0.
- Win: num_players=2 (chickens at 0 and 4); match tiles 1,2,3, then hop to 5 -> tails[0]=2, win=1, winner=0. Further guesses are ignored and ready=0 until start.
- Robustness:
  - Wrap: chicken 3 at 15 matching tile 0 sets pos=0.
  - guess_valid held during SCAN gets no second accept.
  - tile_we during READY leaves the RAM unchanged.
  - Reset mid-SCAN -> all outputs 0, state IDLE.
